celement_sbn: RTL and testbench

CELEMENT_SBN -- requirements
Module: celement_sbn

---
 rtl/celement_pkg.sv | 21 ++
 rtl/sb_senddelay.sv | 34 +++
 rtl/celement_sbn.sv | 148 ++++++++++++++
 tb/tb_celement_sbn.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/celement_pkg.sv
// Shared FSM state type, select-width helper and legal parameter ranges for celement_sbn.
package celement_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_SEND,
    ST_RTZ
  } state_t;

  localparam int N_OUT_MIN      = 2;
  localparam int N_OUT_MAX      = 8;
  localparam int SEND_DELAY_MIN = 1;
  localparam int SEND_DELAY_MAX = 15;

  // Branch-select width: clog2 of the branch count, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sb_senddelay.sv
// Loadable down-counter with a done flag that times the DELAY state of celement_sbn.
// Compiled only when CELEMENT_SBN_SENDDELAY_EN is defined.
`ifdef CELEMENT_SBN_SENDDELAY_EN
module sb_senddelay
  import celement_pkg::*;
#(
  parameter int LOAD_VAL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int CNT_W = $clog2(SEND_DELAY_MAX + 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= CNT_W'(LOAD_VAL);
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  // Done marks the last delay cycle so the FSM enters SEND after exactly LOAD_VAL cycles.
  assign done = (count_reg == CNT_W'(1));

endmodule
`endif

// File: rtl/celement_sbn.sv
// Four-phase C-element style branch: captures a token, steers it to one of N_OUT outputs.
// Optional DELAY state between capture and send is enabled by CELEMENT_SBN_SENDDELAY_EN.
module celement_sbn
  import celement_pkg::*;
#(
  parameter  int N_OUT      = 2,
  parameter  int DATA_W     = 8,
  parameter  int SEND_DELAY = 4,
  localparam int SEL_W      = sel_width(N_OUT)
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              SENDIN,
  input  logic [SEL_W-1:0]  BRIN,
  input  logic [DATA_W-1:0] DATAIN,
  input  logic              LOPEN,
  input  logic [N_OUT-1:0]  ACKIN,
  output logic              ACKOUT,
  output logic [N_OUT-1:0]  SENDOUT,
  output logic [DATA_W-1:0] DATAOUT,
  output logic              CP,
  output logic              ERR
);

  if (N_OUT < N_OUT_MIN || N_OUT > N_OUT_MAX) begin : g_bad_n_out
    $error("celement_sbn: N_OUT outside legal range");
  end
  if (SEND_DELAY < SEND_DELAY_MIN || SEND_DELAY > SEND_DELAY_MAX) begin : g_bad_delay
    $error("celement_sbn: SEND_DELAY outside legal range");
  end

  state_t             state_reg, state_next;
  logic [SEL_W-1:0]   sel_reg, sel_next;
  logic [DATA_W-1:0]  data_reg, data_next;
  logic [N_OUT-1:0]   sendout_reg, sendout_next;
  logic               ackout_reg, ackout_next;
  logic               cp_reg, cp_next;
  logic               err_reg, err_next;
  logic               armed_reg;

  logic [N_OUT-1:0]   sel_onehot;
  logic               ack_sel;
  logic               capture;
  logic               brin_bad;
  logic [SEL_W-1:0]   brin_sat;

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_dec
    assign sel_onehot[gi] = (sel_reg == SEL_W'(gi));
  end

  // Only the acknowledge of the selected branch is ever observed.
  assign ack_sel  = |(ACKIN & sel_onehot);
  assign brin_bad = ({1'b0, BRIN} >= (SEL_W + 1)'(N_OUT));
  assign brin_sat = brin_bad ? SEL_W'(N_OUT - 1) : BRIN;
  // armed_reg keeps the first edge after reset release from capturing.
  assign capture  = armed_reg && SENDIN && LOPEN;

`ifdef CELEMENT_SBN_SENDDELAY_EN
  logic dly_load, dly_dec, dly_done;
  assign dly_load = (state_reg == ST_IDLE) && capture;
  assign dly_dec  = (state_reg == ST_DELAY);

  sb_senddelay #(
    .LOAD_VAL (SEND_DELAY)
  ) u_senddelay (
    .clk   (CLK),
    .rst_n (RESETN),
    .load  (dly_load),
    .dec   (dly_dec),
    .done  (dly_done)
  );
`endif

  always_comb begin
    state_next   = state_reg;
    sel_next     = sel_reg;
    data_next    = data_reg;
    sendout_next = sendout_reg;
    ackout_next  = ackout_reg;
    cp_next      = 1'b0;
    err_next     = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (capture) begin
          data_next = DATAIN;
          sel_next  = brin_sat;
          cp_next   = 1'b1;
          err_next  = err_reg | brin_bad;
`ifdef CELEMENT_SBN_SENDDELAY_EN
          state_next = ST_DELAY;
`else
          state_next = ST_SEND;
`endif
        end
      end
`ifdef CELEMENT_SBN_SENDDELAY_EN
      ST_DELAY: begin
        if (dly_done) state_next = ST_SEND;
      end
`endif
      ST_SEND: begin
        if (ack_sel) begin
          ackout_next  = 1'b1;
          sendout_next = '0;
          state_next   = ST_RTZ;
        end else begin
          sendout_next = sel_onehot;
        end
      end
      ST_RTZ: begin
        if (!SENDIN && !ack_sel) begin
          ackout_next = 1'b0;
          state_next  = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_reg   <= ST_IDLE;
      sel_reg     <= '0;
      data_reg    <= '0;
      sendout_reg <= '0;
      ackout_reg  <= 1'b0;
      cp_reg      <= 1'b0;
      err_reg     <= 1'b0;
      armed_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sel_reg     <= sel_next;
      data_reg    <= data_next;
      sendout_reg <= sendout_next;
      ackout_reg  <= ackout_next;
      cp_reg      <= cp_next;
      err_reg     <= err_next;
      armed_reg   <= 1'b1;
    end
  end

  assign ACKOUT  = ackout_reg;
  assign SENDOUT = sendout_reg;
  assign DATAOUT = data_reg;
  assign CP      = cp_reg;
  assign ERR     = err_reg;

endmodule

// File: tb/tb_celement_sbn.sv
// Self-checking bench for celement_sbn (N_OUT=3): directed handshakes plus random stimulus vs a token-level model.
module tb_celement_sbn;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int SD = 4;
`ifdef CELEMENT_SBN_SENDDELAY_EN
  localparam int DLY = SD;
`else
  localparam int DLY = 0;
`endif

  logic          clk = 1'b0, rstn = 1'b0, sendin = 1'b0, lopen = 1'b1;
  logic [1:0]    brin = '0;
  logic [DW-1:0] datain = '0;
  logic [N-1:0]  ackin = '0;
  logic          ackout, cp, err;
  logic [N-1:0]  sendout;
  logic [DW-1:0] dataout;

  int n_pass = 0, n_total = 0, cp_cnt = 0;
  bit chk_en = 1'b0;

  celement_sbn #(.N_OUT(N), .DATA_W(DW), .SEND_DELAY(SD)) dut (
    .CLK(clk), .RESETN(rstn), .SENDIN(sendin), .BRIN(brin), .DATAIN(datain),
    .LOPEN(lopen), .ACKIN(ackin), .ACKOUT(ackout), .SENDOUT(sendout),
    .DATAOUT(dataout), .CP(cp), .ERR(err)
  );

  always #5 clk = ~clk;

  // Token-level model: a captured token waits DLY+1 edges, then offers itself until acked,
  // then waits for the upstream and selected downstream to both go low.
  bit            m_tok = 0, m_acked = 0, m_armed = 0, m_cp = 0, m_err = 0, m_ackout = 0;
  int            m_age = 0, m_sel = 0;
  logic [N-1:0]  m_sendout = '0;
  logic [DW-1:0] m_data = '0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_tok = 0; m_acked = 0; m_armed = 0; m_cp = 0; m_err = 0; m_ackout = 0;
      m_age = 0; m_sel = 0; m_sendout = '0; m_data = '0;
    end else begin
      m_cp = 0;
      if (!m_tok) begin
        if (m_armed && sendin && lopen) begin
          m_tok = 1; m_acked = 0; m_age = 0; m_data = datain; m_cp = 1;
          if (int'(brin) >= N) begin m_sel = N - 1; m_err = 1; end
          else m_sel = int'(brin);
        end
      end else if (!m_acked) begin
        m_age++;
        if (m_age > DLY) begin
          if (ackin[m_sel]) begin m_acked = 1; m_ackout = 1; m_sendout = '0; end
          else begin m_sendout = '0; m_sendout[m_sel] = 1'b1; end
        end
      end else if (!sendin && !ackin[m_sel]) begin
        m_tok = 0; m_ackout = 0;
      end
      m_armed = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_total++;
      if (sendout === m_sendout && ackout === m_ackout && cp === m_cp && err === m_err && dataout === m_data)
        n_pass++;
      else
        $display("FAIL model_cmp t=%0t got so=%b ack=%b cp=%b err=%b do=%h want so=%b ack=%b cp=%b err=%b do=%h",
                 $time, sendout, ackout, cp, err, dataout, m_sendout, m_ackout, m_cp, m_err, m_data);
    end
  end

  always @(negedge clk) if (cp === 1'b1) cp_cnt++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  task automatic wait_sendout(input string name);
    int i = 0;
    while (sendout === '0 && i < 50) begin @(negedge clk); i++; end
    n_total++;
    if (sendout !== '0) n_pass++;
    else $display("FAIL %s: timeout waiting for sendout, got %b want nonzero", name, sendout);
  endtask

  task automatic wait_ackout(input logic want, input string name);
    int i = 0;
    while (ackout !== want && i < 50) begin @(negedge clk); i++; end
    check(name, ackout, want);
  endtask

  task automatic finish_token(input string name);
    ackin = '0;
    wait_sendout(name);
    ackin = sendout;
    wait_ackout(1'b1, name);
    sendin = 1'b0; ackin = '0;
    wait_ackout(1'b0, name);
  endtask

  // Full four-phase handshake with literal expectations; called at a negedge with the DUT idle.
  task automatic run_token(input logic [1:0] b, input logic [7:0] d, input logic [2:0] exp_so, input logic exp_err);
    sendin = 1'b1; brin = b; datain = d;
    @(negedge clk);
    check("cp_pulse", cp, 1); check("dataout_cap", dataout, d); check("err_cap", err, exp_err);
    datain = ~d; ackin = ~exp_so;
    repeat (DLY) begin @(negedge clk); check("sendout_delay", sendout, 0); end
    @(negedge clk);
    check("sendout_sel", sendout, exp_so); check("cp_single", cp, 0);
    ackin = exp_so;
    @(negedge clk);
    check("ackout_rise", ackout, 1); check("sendout_drop", sendout, 0);
    sendin = 1'b0; ackin = '0;
    @(negedge clk);
    check("ackout_fall", ackout, 0); check("err_hold", err, exp_err); check("dataout_hold", dataout, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    repeat (3) @(negedge clk);
    check("rst_sendout", sendout, 0); check("rst_ackout", ackout, 0); check("rst_cp", cp, 0);
    check("rst_err", err, 0); check("rst_dataout", dataout, 0);
    chk_en = 1'b1;
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    run_token(2'd2, 8'hA5, 3'b100, 1'b0);
    run_token(2'd0, 8'h3C, 3'b001, 1'b0);
    run_token(2'd1, 8'h5A, 3'b010, 1'b0);
    run_token(2'd3, 8'hF0, 3'b100, 1'b1);
    run_token(2'd1, 8'h0F, 3'b010, 1'b1);

    // LOPEN low blocks capture; raising it captures on the next edge.
    lopen = 1'b0; sendin = 1'b1; brin = 2'd1; datain = 8'h77;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); check("lopen_cp", cp, 0); check("lopen_so", sendout, 0);
    end
    lopen = 1'b1;
    @(negedge clk); check("lopen_capture", cp, 1);
    finish_token("lopen_hs");

    // Reset during SEND with a non-selected acknowledge high.
    brin = 2'd0; datain = 8'h11; sendin = 1'b1; ackin = 3'b010;
    @(negedge clk);
    wait_sendout("rst_pre");
    check("rst_pre_so", sendout, 3'b001);
    #2 rstn = 1'b0;
    #1;
    check("arst_so", sendout, 0); check("arst_ack", ackout, 0); check("arst_cp", cp, 0);
    check("arst_err", err, 0); check("arst_do", dataout, 0);
    sendin = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1; sendin = 1'b1; brin = 2'd2; datain = 8'h66;
    @(negedge clk); check("post_rst_edge1_cp", cp, 0); check("post_rst_ack", ackout, 0);
    @(negedge clk); check("post_rst_edge2_cp", cp, 1);
    wait_sendout("post_rst");
    check("post_rst_so", sendout, 3'b100); check("post_rst_noack", ackout, 0);
    finish_token("post_rst_hs");

    // Back-to-back tokens with SENDIN held high through RTZ.
    start = cp_cnt;
    sendin = 1'b1; lopen = 1'b1;
    for (int t = 0; t < 3; t++) begin
      brin = 2'(t);
      wait_sendout("b2b_so");
      ackin = sendout;
      wait_ackout(1'b1, "b2b_ack");
      ackin = '0;
      repeat (3) begin @(negedge clk); check("b2b_no_recap", cp, 0); end
      sendin = 1'b0;
      @(negedge clk);
      check("b2b_release", ackout, 0);
      if (t < 2) sendin = 1'b1;
    end
    check("b2b_cp_count", 32'(cp_cnt - start), 3);

    // Random stimulus against the model, with rare asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      sendin = ($urandom_range(0, 1) == 1);
      lopen  = ($urandom_range(0, 3) != 0);
      brin   = 2'($urandom_range(0, 3));
      datain = 8'($urandom);
      ackin  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 499) == 0) begin
        #3 rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
      end
    end
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
